// File: rtl/tap_controller_if.sv
// tap_controller_if: JTAG pins plus boundary-scan cell controls for tap_controller
interface tap_controller_if;
    logic TMS;
    logic TDI;
    logic TDO;
    logic TDO_en;
    logic bsr_si;
    logic bsr_so;
    logic ShiftDR;
    logic ClockDR;
    logic UpdateDR;
    logic Mode;
    modport slave (
        input  TMS, TDI, bsr_so,
        output TDO, TDO_en, bsr_si, ShiftDR, ClockDR, UpdateDR, Mode
    );
    modport master (
        output TMS, TDI, bsr_so,
        input  TDO, TDO_en, bsr_si, ShiftDR, ClockDR, UpdateDR, Mode
    );
endinterface

// File: rtl/tap_controller.sv
// tap_controller: IEEE 1149.1 TAP with IR, bypass, optional ID register (TAP_IDCODE_EN) and BSR control
module tap_controller #(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input logic             TCK,
    input logic             TRST_n,
    tap_controller_if.slave tap
);
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
        UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } state_t;

    localparam logic [IR_WIDTH-1:0] IR_EXTEST = '0;
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_BYPASS = '1;
`ifdef TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET  = IR_BYPASS;
`endif

    state_t              r_state;
    logic [IR_WIDTH-1:0] r_ir_sh;
    logic [IR_WIDTH-1:0] r_ir;
    logic                r_byp;
    logic                r_tdo;
    logic                r_tdo_en;
    logic                r_cdr_en;
    logic                w_sel_bsr;
    logic                w_sh_dr;
    logic                w_sh_ir;
    logic                w_dr_out;

    assign w_sel_bsr = (r_ir == IR_EXTEST) || (r_ir == IR_SAMPLE);
    assign w_sh_dr   = (r_state == SH_DR);
    assign w_sh_ir   = (r_state == SH_IR);

`ifdef TAP_IDCODE_EN
    logic [31:0] r_id;
    logic        w_sel_id;
    assign w_sel_id = (r_ir == IR_IDCODE);
    assign w_dr_out = w_sel_bsr ? tap.bsr_so : w_sel_id ? r_id[0] : r_byp;
    // ID register: capture the device word, then shift it out LSB-first filling from TDI
    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) r_id <= '0;
        else if (w_sel_id && r_state == CAP_DR) r_id <= IDCODE_VALUE;
        else if (w_sel_id && w_sh_dr) r_id <= {tap.TDI, r_id[31:1]};
    end
`else
    logic w_unused_idcode;
    assign w_unused_idcode = ^IDCODE_VALUE;
    assign w_dr_out = w_sel_bsr ? tap.bsr_so : r_byp;
`endif

    // TAP state machine, advanced by TMS on the rising edge
    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) r_state <= TLR;
        else begin
            case (r_state)
                TLR:     r_state <= tap.TMS ? TLR    : RTI;
                RTI:     r_state <= tap.TMS ? SEL_DR : RTI;
                SEL_DR:  r_state <= tap.TMS ? SEL_IR : CAP_DR;
                CAP_DR:  r_state <= tap.TMS ? EX1_DR : SH_DR;
                SH_DR:   r_state <= tap.TMS ? EX1_DR : SH_DR;
                EX1_DR:  r_state <= tap.TMS ? UPD_DR : PAU_DR;
                PAU_DR:  r_state <= tap.TMS ? EX2_DR : PAU_DR;
                EX2_DR:  r_state <= tap.TMS ? UPD_DR : SH_DR;
                UPD_DR:  r_state <= tap.TMS ? SEL_DR : RTI;
                SEL_IR:  r_state <= tap.TMS ? TLR    : CAP_IR;
                CAP_IR:  r_state <= tap.TMS ? EX1_IR : SH_IR;
                SH_IR:   r_state <= tap.TMS ? EX1_IR : SH_IR;
                EX1_IR:  r_state <= tap.TMS ? UPD_IR : PAU_IR;
                PAU_IR:  r_state <= tap.TMS ? EX2_IR : PAU_IR;
                EX2_IR:  r_state <= tap.TMS ? UPD_IR : SH_IR;
                UPD_IR:  r_state <= tap.TMS ? SEL_DR : RTI;
                default: r_state <= TLR;
            endcase
        end
    end

    // IR shift stage and bypass bit: capture fixed values, shift in from TDI
    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            r_ir_sh <= '0;
            r_byp   <= 1'b0;
        end else begin
            r_ir_sh <= (r_state == CAP_IR) ? IR_WIDTH'(1) : w_sh_ir ? {tap.TDI, r_ir_sh[IR_WIDTH-1:1]} : r_ir_sh;
            r_byp   <= (r_state == CAP_DR) ? 1'b0 : w_sh_dr ? tap.TDI : r_byp;
        end
    end

    // Falling-edge side: IR hold update, TDO launch and ClockDR enable (stable through TCK high)
    always_ff @(negedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            r_ir     <= IR_RESET;
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
            r_cdr_en <= 1'b0;
        end else begin
            r_ir     <= (r_state == TLR) ? IR_RESET : (r_state == UPD_IR) ? r_ir_sh : r_ir;
            r_tdo    <= w_sh_ir ? r_ir_sh[0] : w_sh_dr ? w_dr_out : 1'b0;
            r_tdo_en <= w_sh_ir || w_sh_dr;
            r_cdr_en <= w_sel_bsr && (r_state == CAP_DR || w_sh_dr);
        end
    end

    assign tap.TDO      = r_tdo;
    assign tap.TDO_en   = r_tdo_en;
    assign tap.bsr_si   = tap.TDI;
    assign tap.ShiftDR  = w_sh_dr && w_sel_bsr;
    assign tap.ClockDR  = TCK && r_cdr_en;
    assign tap.UpdateDR = !TCK && (r_state == UPD_DR) && w_sel_bsr;
    assign tap.Mode     = (r_ir == IR_EXTEST);
endmodule

// File: tb/tb_tap_controller.sv
// tb_tap_controller: directed scoreboard bench for tap_controller
module tb_tap_controller;
    localparam logic [31:0] IDV = 32'h4BA0_0477;

    logic TCK = 1'b0;
    logic TRST_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n_cdr = 0;
    int   n_upd = 0;
    int   cdr0, upd0;
    logic q[$];

    tap_controller_if tap_if();
    tap_controller #(.IR_WIDTH(4), .IDCODE_VALUE(IDV)) dut (.TCK(TCK), .TRST_n(TRST_n), .tap(tap_if));

    always #5 TCK = ~TCK;
    always @(posedge tap_if.ClockDR) n_cdr++;
    always @(posedge tap_if.UpdateDR) n_upd++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tck(input logic tms, input logic tdi);
        tap_if.TMS = tms;
        tap_if.TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    task automatic load_ir(input logic [3:0] code, input logic mode_before, input logic mode_after);
        tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        for (int i = 0; i < 4; i++) q.push_back(i == 0);
        for (int i = 0; i < 4; i++) begin
            chk("ir_tdo", tap_if.TDO, q.pop_front());
            chk("ir_tdo_en", tap_if.TDO_en, 1);
            tck(i == 3, code[i]);
        end
        chk("mode_ex1ir", tap_if.Mode, mode_before);
        tck(1, 0);
        chk("mode_updir", tap_if.Mode, mode_after);
        tck(0, 0);
        chk("tdo_en_rti", tap_if.TDO_en, 0);
    endtask

    task automatic shift_dr(input int n, input logic [63:0] tdi, input logic [63:0] so, input int kind);
        tck(1, 0); tck(0, 0);
        tap_if.bsr_so = so[0];
        tck(0, 0);
        for (int i = 0; i < n; i++) begin
            q.push_back(kind == 2 ? so[i] : kind == 1 ? IDV[i] : (i == 0 ? 1'b0 : tdi[i-1]));
            chk("dr_tdo", tap_if.TDO, q.pop_front());
            chk("dr_tdo_en", tap_if.TDO_en, 1);
            chk("shiftdr", tap_if.ShiftDR, kind == 2);
            if (i < n - 1) tap_if.bsr_so = so[i+1];
            tck(i == n - 1, tdi[i]);
        end
        chk("shiftdr_ex1", tap_if.ShiftDR, 0);
        tck(1, 0);
        chk("updatedr", tap_if.UpdateDR, kind == 2);
        tck(0, 0);
    endtask

    task automatic default_dr();
`ifdef TAP_IDCODE_EN
        shift_dr(32, 64'h0, 64'h0, 1);
`else
        shift_dr(8, 64'hA5, 64'h0, 0);
`endif
    endtask

    initial begin
        tap_if.TMS = 1'b1;
        tap_if.TDI = 1'b0;
        tap_if.bsr_so = 1'b0;
        repeat (2) @(negedge TCK);
        #1;
        chk("rst_mode", tap_if.Mode, 0);
        chk("rst_tdo", tap_if.TDO, 0);
        chk("rst_tdo_en", tap_if.TDO_en, 0);
        chk("rst_shiftdr", tap_if.ShiftDR, 0);
        chk("rst_clockdr", tap_if.ClockDR, 0);
        chk("rst_updatedr", tap_if.UpdateDR, 0);
        chk("bsr_si_0", tap_if.bsr_si, 0);
        tap_if.TDI = 1'b1;
        #1;
        chk("bsr_si_1", tap_if.bsr_si, 1);
        TRST_n = 1'b1;
        tck(0, 0);

        default_dr();
        chk("no_clockdr_default", n_cdr, 0);
        chk("no_updatedr_default", n_upd, 0);

        load_ir(4'b1111, 0, 0);
        shift_dr(4, 64'b1101, 64'h0, 0);

        load_ir(4'b0000, 0, 1);
        cdr0 = n_cdr;
        upd0 = n_upd;
        shift_dr(4, 64'b0110, 64'b1010, 2);
        chk("extest_clockdr_edges", n_cdr - cdr0, 5);
        chk("extest_updatedr_pulses", n_upd - upd0, 1);
        chk("extest_mode", tap_if.Mode, 1);

        load_ir(4'b0001, 1, 0);
        cdr0 = n_cdr;
        shift_dr(3, 64'b011, 64'b110, 2);
        chk("sample_clockdr_edges", n_cdr - cdr0, 4);

        load_ir(4'b0000, 0, 1);
        tck(1, 0); tck(0, 0); tck(0, 0);
        chk("tms5_shiftdr", tap_if.ShiftDR, 1);
        repeat (5) tck(1, 0);
        chk("tms5_mode", tap_if.Mode, 0);
        chk("tms5_tdo_en", tap_if.TDO_en, 0);
        tck(0, 0);
        default_dr();

        load_ir(4'b0000, 0, 1);
        tck(1, 0); tck(0, 0); tck(0, 0); tck(0, 1);
        tap_if.TMS = 1'b1;
        @(posedge TCK);
        #2;
        TRST_n = 1'b0;
        #1;
        cdr0 = n_cdr;
        upd0 = n_upd;
        chk("trst_mode", tap_if.Mode, 0);
        chk("trst_shiftdr", tap_if.ShiftDR, 0);
        chk("trst_clockdr", tap_if.ClockDR, 0);
        chk("trst_tdo_en", tap_if.TDO_en, 0);
        repeat (3) @(negedge TCK);
        #1;
        chk("trst_no_clockdr", n_cdr, cdr0);
        chk("trst_no_updatedr", n_upd, upd0);
        chk("trst_tdo", tap_if.TDO, 0);
        TRST_n = 1'b1;
        tck(0, 0);
        default_dr();
        chk("final_mode", tap_if.Mode, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
